// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package clk_div_pkg;

  localparam int unsigned DEF_DIV_W       = 8;
  localparam int unsigned DEF_DEFAULT_DIV = 4;
  localparam int unsigned DEF_LOCK_CYCLES = 16;

  // FSM encoding
  localparam logic [0:0] SETTLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: programmable ratio, free-running counter, registered
// clock-enable pulse and divided clock.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             gate,
  input  logic             restart,
  output logic             ce,
  output logic             clk_div
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             ce_q;
  logic             clk_q;
  logic             wrap;

  assign wrap    = (cnt_q == (div_q - DIV_W'(1)));
  assign ce      = ce_q;
  assign clk_div = clk_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(DEFAULT_DIV);
      cnt_q <= '0;
      ce_q  <= 1'b0;
      clk_q <= 1'b0;
    end else if (load) begin
      div_q <= load_div;
      cnt_q <= '0;
      ce_q  <= 1'b0;
      clk_q <= 1'b0;
    end else if (restart || gate) begin
      // Gated channels park; restart re-phases the counter to zero.
      if (restart) cnt_q <= '0;
      ce_q  <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + DIV_W'(1);
      ce_q  <= wrap;
      clk_q <= (cnt_q < (div_q >> 1));
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator: settle/lock FSM, runtime ratio
// reconfiguration handshake. Define CLKGEN_PHASE_SYNC_EN to re-phase all channels on relock.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  localparam int unsigned CH_W       = ch_width(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

`ifdef CLKGEN_PHASE_SYNC_EN
  localparam bit PHASE_SYNC = 1'b1;
`else
  localparam bit PHASE_SYNC = 1'b0;
`endif

  localparam int unsigned SET_W = ch_width(LOCK_CYCLES);

  logic [0:0]        state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic              err_q, err_d;
  logic              boot_q;
  logic              fire, bad, accept, exit_settle;
  logic [NUM_CH-1:0] load, gate, restart;

  assign cfg_ready = (state_q == LOCKED);
  assign locked    = (state_q == LOCKED);
  assign cfg_err   = err_q;

  always_comb begin
    fire        = cfg_valid && cfg_ready;
    bad         = (cfg_div < DIV_W'(2)) || (32'(cfg_ch) >= NUM_CH);
    accept      = fire && !bad;
    exit_settle = (state_q == SETTLE) && (settle_q == SET_W'(LOCK_CYCLES - 1));

    state_d  = state_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    err_d    = fire && bad;

    if (state_q == SETTLE) begin
      if (exit_settle) state_d = LOCKED;
      else             settle_d = settle_q + SET_W'(1);
    end else if (accept) begin
      state_d  = SETTLE;
      settle_d = '0;
      sel_d    = PHASE_SYNC ? {NUM_CH{1'b1}} : (NUM_CH'(1) << cfg_ch);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      load[i]    = accept && (cfg_ch == CH_W'(i));
      gate[i]    = (state_q == SETTLE) && sel_q[i];
      // boot_q makes the first edge after reset act as a restart edge.
      restart[i] = boot_q || (exit_settle && sel_q[i]) || (PHASE_SYNC && accept);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      sel_q    <= {NUM_CH{PHASE_SYNC}};
      err_q    <= 1'b0;
      boot_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      boot_q   <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .load    (load[g]),
      .load_div(cfg_div),
      .gate    (gate[g]),
      .restart (restart[g]),
      .ce      (ce_out[g]),
      .clk_div (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: random reconfiguration traffic checked
// against a phase-origin model (each channel pulses div cycles after its restart edge).
module tb_clk_div_gen;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned DIV_W       = 8;
  localparam int unsigned DEFAULT_DIV = 4;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam int unsigned CH_W        = 2;

`ifdef CLKGEN_PHASE_SYNC_EN
  localparam bit PHASE_EN = 1'b1;
`else
  localparam bit PHASE_EN = 1'b0;
`endif

  logic              clk_in    = 1'b0;
  logic              rst_n     = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch    = '0;
  logic [DIV_W-1:0]  cfg_div   = '0;
  logic              cfg_ready, cfg_err, locked;
  logic [NUM_CH-1:0] ce_out, clk_out;

  clk_div_gen #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .ce_out   (ce_out),
    .clk_out  (clk_out),
    .locked   (locked)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: edge count since reset release, per-channel ratio and
  // restart edge, gating set and lock window origin.
  int n, settle_start;
  bit lck, err_m, fired;
  int div_m [NUM_CH];
  int t0    [NUM_CH];
  bit gated [NUM_CH];
  int n_cmp = 0, n_bad = 0;
  int r_ch, r_dv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic void model_reset();
    n = 0; settle_start = 0; lck = 0; err_m = 0; fired = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_m[i] = DEFAULT_DIV;
      t0[i]    = 1;
      gated[i] = PHASE_EN;
    end
  endfunction

  function automatic void model_edge();
    n++; fired = 0; err_m = 0;
    if (!lck) begin
      if (n == settle_start + LOCK_CYCLES) begin
        lck = 1;
        for (int i = 0; i < NUM_CH; i++)
          if (gated[i]) begin t0[i] = n; gated[i] = 0; end
      end
    end else if (cfg_valid) begin
      fired = 1;
      if (cfg_div < 2 || cfg_ch >= NUM_CH) err_m = 1;
      else begin
        div_m[cfg_ch] = cfg_div;
        settle_start  = n;
        lck           = 0;
        for (int i = 0; i < NUM_CH; i++) gated[i] = PHASE_EN || (i == int'(cfg_ch));
      end
    end
  endfunction

  function automatic logic exp_ce(int i);
    if (gated[i] || n <= t0[i]) return 1'b0;
    return ((n - t0[i] - 1) % div_m[i]) == div_m[i] - 1;
  endfunction

  function automatic logic exp_clk(int i);
    if (gated[i] || n <= t0[i]) return 1'b0;
    return ((n - t0[i] - 1) % div_m[i]) < div_m[i] / 2;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("ce_out[%0d]", i), ce_out[i], exp_ce(i));
      check($sformatf("clk_out[%0d]", i), clk_out[i], exp_clk(i));
    end
    check("locked", locked, lck);
    check("cfg_ready", cfg_ready, lck);
    check("cfg_err", cfg_err, err_m);
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  // Hold a request until the block consumes it (accept or reject).
  task automatic send(input int ch, input int dv, input int budget);
    bit done;
    done      = 0;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_valid = 1'b1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (fired) begin done = 1; break; end
    end
    cfg_valid = 1'b0;
    check("send_consumed", done, 1);
  endtask

  // Asynchronous assertion mid-cycle, release on a falling edge.
  task automatic do_reset();
    @(posedge clk_in);
    #2;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check("rst_ce_out", ce_out, 0);
    check("rst_clk_out", clk_out, 0);
    check("rst_locked", locked, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_cfg_err", cfg_err, 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    do_reset();
    idle(30);
    send(1, 5, 40);  idle(40);
    send(1, 1, 5);   idle(3);
    send(3, 7, 5);   idle(3);
    send(0, 6, 5);   idle(2);
    send(2, 3, 40);  idle(30);   // held through SETTLE, consumed once
    send(2, 3, 40);  idle(20);   // same ratio still relocks
    send(2, 255, 40); idle(530);
    send(2, 2, 40);  idle(20);
    for (int t = 0; t < 25; t++) begin
      r_ch = $urandom_range(0, 3);
      r_dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12);
      send(r_ch, r_dv, 40);
      idle($urandom_range(0, 30));
    end
    send(1, 9, 40);  idle(5);
    do_reset();
    idle(20);
    send(0, 6, 40);  idle(40);   // ch0 at 6 against ch1 at 4
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
